// File: rtl/sniffer_pkg.sv
// Shared record layout for the bus sniffer capture path: field positions,
// the 64-bit record type and a record packing helper.
package sniffer_pkg;

  localparam int REC_LOST_BIT = 63;
  localparam int REC_DELTA_HI = 62;
  localparam int REC_DELTA_LO = 48;
  localparam int REC_PROBE_W  = 48;
  localparam int REC_DELTA_W  = REC_DELTA_HI - REC_DELTA_LO + 1;

  localparam logic [REC_DELTA_W-1:0] DELTA_MAX = 15'h7FFF;

  typedef logic [63:0] sniffer_rec_t;

  function automatic sniffer_rec_t make_rec(input logic                   lost,
                                            input logic [REC_DELTA_W-1:0] delta,
                                            input logic [REC_PROBE_W-1:0] value);
    return {lost, delta, value};
  endfunction

endpackage

// File: rtl/bus_sniffer_capture_if.sv
// Record delivery bus from the sniffer to the DRAM writer: one 64-bit record
// word held between strobes plus a one-cycle strobe.
interface bus_sniffer_capture_if;
  import sniffer_pkg::*;

  sniffer_rec_t sniffer_data;
  logic         sniffer_data_stb;

  modport master (output sniffer_data, output sniffer_data_stb);
  modport slave  (input  sniffer_data, input  sniffer_data_stb);

endinterface

// File: rtl/sniffer_fifo.sv
// Synchronous first-word-fall-through record FIFO, FIFO_DEPTH entries of
// 64 bits; dout always shows the head entry.
module sniffer_fifo
  import sniffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  sniffer_rec_t din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output sniffer_rec_t dout
);

  localparam int AW = $clog2(FIFO_DEPTH);

  sniffer_rec_t      mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_sniffer_capture.sv
// Probe bus change capture with paced record delivery and masked trigger.
// Optional macro SNIFFER_TSTAMP_EN adds the cycle-delta timestamp and keepalive.
module bus_sniffer_capture
  import sniffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_GAP    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REC_PROBE_W-1:0] probe,
  input  logic [REC_PROBE_W-1:0] change_mask,
  input  logic [REC_PROBE_W-1:0] trig_mask,
  input  logic [REC_PROBE_W-1:0] trig_value,
  input  logic                   arm,
  bus_sniffer_capture_if.master  rec,
  output logic                   trigger,
  output logic [15:0]            drop_count
);

  localparam int GAP_W = $clog2(MIN_GAP);

  logic [REC_PROBE_W-1:0] p1;
  logic [REC_PROBE_W-1:0] p2;
  logic [REC_PROBE_W-1:0] last;
  logic [REC_DELTA_W-1:0] delta;
  logic [GAP_W-1:0]       gap;
  logic                   change;
  logic                   keepalive;
  logic                   enq;
  logic                   push;
  logic                   pop;
  logic                   lost;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   match;
  logic                   match_d;
  sniffer_rec_t           fifo_din;
  sniffer_rec_t           fifo_dout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= probe;
      p2 <= p1;
    end
  end

  assign change = |((p2 ^ last) & change_mask);

`ifdef SNIFFER_TSTAMP_EN
  logic [REC_DELTA_W-1:0] cnt;

  // Forcing a record at DELTA_MAX restarts cnt, so it can never wrap.
  assign keepalive = (cnt == DELTA_MAX) && !change;
  assign delta     = cnt;

  // Restarts on every enqueue attempt, including dropped ones.
  always_ff @(posedge clk) begin
    if (!reset)   cnt <= '0;
    else if (enq) cnt <= REC_DELTA_W'(1);
    else          cnt <= cnt + REC_DELTA_W'(1);
  end
`else
  assign keepalive = 1'b0;
  assign delta     = '0;
`endif

  assign enq      = change || keepalive;
  assign push     = enq && !fifo_full;
  assign pop      = !fifo_empty && (gap == '0);
  assign fifo_din = make_rec(lost, delta, p2);

  // last follows dropped values too, so a lost value is not re-detected.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last       <= '0;
      lost       <= 1'b0;
      drop_count <= '0;
    end else if (enq) begin
      last <= p2;
      if (fifo_full) begin
        lost <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else begin
        lost <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rec.sniffer_data     <= '0;
      rec.sniffer_data_stb <= 1'b0;
      gap                  <= '0;
    end else if (pop) begin
      rec.sniffer_data     <= fifo_dout;
      rec.sniffer_data_stb <= 1'b1;
      gap                  <= GAP_W'(MIN_GAP - 1);
    end else begin
      rec.sniffer_data_stb <= 1'b0;
      if (gap != '0) gap <= gap - GAP_W'(1);
    end
  end

  assign match = ((p2 ^ trig_value) & trig_mask) == '0;

  // match_d starts high so a pattern present at reset release does not fire.
  always_ff @(posedge clk) begin
    if (!reset) begin
      match_d <= 1'b1;
      trigger <= 1'b0;
    end else begin
      match_d <= match;
      trigger <= arm && match && !match_d;
    end
  end

  sniffer_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

endmodule
